mantissa_shf_left_norm: RTL and testbench

//  Post-add normalizer for the FP adder datapath; the counterpart of the alignment right-shifter.

---
 rtl/mantissa_shf_left_norm.sv | 196 +++++++++++++++++++
 tb/tb_mantissa_shf_left_norm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mantissa_shf_left_norm.sv
// rtl/mantissa_shf_left_norm.sv - post-add mantissa left normalizer, SHIFT_STEP bits per cycle
// Optional feature macro: MANTISSA_NORM_EXP_CLAMP_EN (clamp shift so the exponent stays >= 1)
module mantissa_shf_left_norm #(
    parameter int SIZE_DATA  = 28,
    parameter int SIZE_SHIFT = 8,
    parameter int SHIFT_STEP = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SIZE_DATA-1:0]  i_data,
    input  logic [SIZE_SHIFT-1:0] i_exp,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE_DATA-1:0]  o_data,
    output logic [SIZE_SHIFT-1:0] o_exp,
    output logic [SIZE_SHIFT-1:0] o_shift_number,
    output logic                  o_zero,
    output logic                  o_underflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SIZE_DATA-1:0]  data_q, data_d;
    logic [SIZE_SHIFT-1:0] exp_q, exp_d;
    logic [SIZE_SHIFT-1:0] cnt_q, cnt_d;
    logic [SIZE_DATA-1:0]  out_data_q, out_data_d;
    logic [SIZE_SHIFT-1:0] out_exp_q, out_exp_d;
    logic [SIZE_SHIFT-1:0] out_shift_q, out_shift_d;
    logic                  zero_q, zero_d;
    logic                  underflow_q, underflow_d;
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
    logic [SIZE_SHIFT-1:0] allow_q, allow_d;
`endif

    logic [SIZE_SHIFT-1:0] lz;
    logic [SIZE_SHIFT-1:0] amt;
    logic [SIZE_DATA-1:0]  data_sh;
    logic [SIZE_SHIFT-1:0] cnt_sum;
    logic                  last_step;
    logic [SIZE_SHIFT-1:0] res_exp;
    logic                  res_underflow;

    // Leading zeros within the top SHIFT_STEP bits; the highest set bit wins
    always_comb begin
        lz = SIZE_SHIFT'(SHIFT_STEP);
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (data_q[SIZE_DATA-SHIFT_STEP+i]) begin
                lz = SIZE_SHIFT'(SHIFT_STEP - 1 - i);
            end
        end
    end

    // One shift step: amount (optionally clamped), shifted data, running count, termination
    always_comb begin
        amt = lz;
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
        if (lz > allow_q) begin
            amt = allow_q;
        end
`endif
        data_sh   = data_q << amt;
        cnt_sum   = cnt_q + amt;
        last_step = (lz != SIZE_SHIFT'(SHIFT_STEP));
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
        if (amt == allow_q) begin
            last_step = 1'b1;
        end
`endif
    end

    // Final exponent and underflow flag for the step that ends the shift
    always_comb begin
        res_exp       = exp_q - cnt_sum;
        res_underflow = 1'b0;
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
        // Clamp stopped short of normalization: encode as subnormal
        if (!data_sh[SIZE_DATA-1]) begin
            res_exp = '0;
        end
`else
        if (cnt_sum >= exp_q) begin
            res_exp       = '0;
            res_underflow = 1'b1;
        end
`endif
    end

    // Next-state and datapath update for the IDLE -> SHIFT | DONE -> IDLE handshake FSM
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_exp_d   = out_exp_q;
        out_shift_d = out_shift_q;
        zero_d      = zero_q;
        underflow_d = underflow_q;
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
        allow_d     = allow_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    data_d = i_data;
                    exp_d  = i_exp;
                    cnt_d  = '0;
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
                    allow_d = (i_exp == '0) ? '0 : (i_exp - SIZE_SHIFT'(1));
`endif
                    if (i_data == '0) begin
                        // Zero mantissa needs no shifting; report it directly
                        state_d     = ST_DONE;
                        out_data_d  = '0;
                        out_exp_d   = '0;
                        out_shift_d = '0;
                        zero_d      = 1'b1;
                        underflow_d = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d = data_sh;
                cnt_d  = cnt_sum;
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
                allow_d = allow_q - amt;
`endif
                if (last_step) begin
                    state_d     = ST_DONE;
                    out_data_d  = data_sh;
                    out_exp_d   = res_exp;
                    out_shift_d = cnt_sum;
                    zero_d      = 1'b0;
                    underflow_d = res_underflow;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset discards any in-flight operand
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_exp_q   <= '0;
            out_shift_q <= '0;
            zero_q      <= 1'b0;
            underflow_q <= 1'b0;
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
            allow_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_exp_q   <= out_exp_d;
            out_shift_q <= out_shift_d;
            zero_q      <= zero_d;
            underflow_q <= underflow_d;
`ifdef MANTISSA_NORM_EXP_CLAMP_EN
            allow_q     <= allow_d;
`endif
        end
    end

    assign o_ready        = (state_q == ST_IDLE);
    assign o_valid        = (state_q == ST_DONE);
    assign o_data         = out_data_q;
    assign o_exp          = out_exp_q;
    assign o_shift_number = out_shift_q;
    assign o_zero         = zero_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_mantissa_shf_left_norm.sv
// tb/tb_mantissa_shf_left_norm.sv - directed self-checking bench for mantissa_shf_left_norm
module tb_mantissa_shf_left_norm;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [27:0] i_data;
    logic [7:0]  i_exp;
    logic        o_valid;
    logic        i_ready;
    logic [27:0] o_data;
    logic [7:0]  o_exp;
    logic [7:0]  o_shift_number;
    logic        o_zero;
    logic        o_underflow;

    int n_vec;
    int n_err;

    mantissa_shf_left_norm #(
        .SIZE_DATA  (28),
        .SIZE_SHIFT (8),
        .SHIFT_STEP (4)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .i_exp          (i_exp),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_exp          (o_exp),
        .o_shift_number (o_shift_number),
        .o_zero         (o_zero),
        .o_underflow    (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [27:0] d, input logic [7:0] e,
                              input logic [7:0] s, input logic z, input logic u);
        chk({tag, " data"},  32'(o_data), 32'(d));
        chk({tag, " exp"},   32'(o_exp), 32'(e));
        chk({tag, " shift"}, 32'(o_shift_number), 32'(s));
        chk({tag, " zero"},  32'(o_zero), 32'(z));
        chk({tag, " uflow"}, 32'(o_underflow), 32'(u));
    endtask

    // Accept edge counts as edge 1; returns after o_valid is seen or the budget expires
    task automatic run_op(input string tag, input logic [27:0] d, input logic [7:0] e,
                          input int lat);
        int edges;
        i_data  = d;
        i_exp   = e;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        edges   = 1;
        while (o_valid !== 1'b1 && edges < 100) begin
            @(posedge i_clk);
            #1;
            edges++;
        end
        chk({tag, " latency"}, 32'(edges), 32'(lat));
        chk({tag, " ready low"}, 32'(o_ready), 32'd0);
    endtask

    task automatic release_op(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk({tag, " idle valid"}, 32'(o_valid), 32'd0);
        chk({tag, " idle ready"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_exp   = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset ready", 32'(o_ready), 32'd1);
        chk("reset valid", 32'(o_valid), 32'd0);
        expect_out("reset", 28'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Already normalized
        run_op("t1", 28'h8000000, 8'd100, 2);
        expect_out("t1", 28'h8000000, 8'd100, 8'd0, 1'b0, 1'b0);
        release_op("t1");

        // Maximum shift
        run_op("t2", 28'h0000001, 8'd100, 8);
        expect_out("t2", 28'h8000000, 8'd73, 8'd27, 1'b0, 1'b0);
        release_op("t2");

        // Zero operand
        run_op("t3", 28'h0, 8'd50, 1);
        expect_out("t3", 28'h0, 8'd0, 8'd0, 1'b1, 1'b0);
        release_op("t3");

        // Leading zeros exactly one step
        run_op("lz4", 28'h0800000, 8'd100, 3);
        expect_out("lz4", 28'h8000000, 8'd96, 8'd4, 1'b0, 1'b0);
        release_op("lz4");

        // Mixed pattern, LZ=7
        run_op("mix", 28'h0123456, 8'd100, 3);
        expect_out("mix", 28'h91A2B00, 8'd93, 8'd7, 1'b0, 1'b0);
        release_op("mix");

`ifdef MANTISSA_NORM_EXP_CLAMP_EN
        run_op("t4", 28'h0100000, 8'd5, 2);
        expect_out("t4", 28'h1000000, 8'd0, 8'd4, 1'b0, 1'b0);
        release_op("t4");
        run_op("exp0", 28'h4000000, 8'd0, 2);
        expect_out("exp0", 28'h4000000, 8'd0, 8'd0, 1'b0, 1'b0);
        release_op("exp0");
`else
        run_op("t4", 28'h0100000, 8'd5, 3);
        expect_out("t4", 28'h8000000, 8'd0, 8'd7, 1'b0, 1'b1);
        release_op("t4");
        run_op("exp0", 28'h4000000, 8'd0, 2);
        expect_out("exp0", 28'h8000000, 8'd0, 8'd1, 1'b0, 1'b1);
        release_op("exp0");
`endif

        // Back-pressure: result held while i_ready=0; a new i_valid is ignored
        run_op("t5", 28'h0000001, 8'd100, 8);
        i_data  = 28'h0000F00;
        i_exp   = 8'd9;
        i_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk);
            #1;
            chk("t5 hold valid", 32'(o_valid), 32'd1);
            chk("t5 hold ready", 32'(o_ready), 32'd0);
            chk("t5 hold data", 32'(o_data), 32'h08000000);
            chk("t5 hold exp", 32'(o_exp), 32'd73);
        end
        i_valid = 1'b0;
        expect_out("t5", 28'h8000000, 8'd73, 8'd27, 1'b0, 1'b0);
        release_op("t5");

        // Reset in the middle of a SHIFT sequence
        i_data  = 28'h0000001;
        i_exp   = 8'd100;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("t6 mid busy", 32'(o_ready), 32'd0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("t6 rst valid", 32'(o_valid), 32'd0);
        chk("t6 rst ready", 32'(o_ready), 32'd1);
        expect_out("t6 rst", 28'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        run_op("t6 t1", 28'h8000000, 8'd100, 2);
        expect_out("t6 t1", 28'h8000000, 8'd100, 8'd0, 1'b0, 1'b0);
        release_op("t6 t1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
